rescale_bilinear_core: RTL

Downstream consumer of the two-row input line buffer in the rescale IP. For each output row it sweeps destination x, drives `neighbor_offset` into the buffer, and captures the four RGB565 neighbours returned combinationally. It blends them bilinearly using fixed-point weights and emits one 32-bit RGB888 pixel per cycle on an AXI4-Stream master, with full backpressure support.

---
 rtl/rescale_bilinear_core.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rescale_bilinear_core.sv
// Bilinear rescale core: sweeps destination x over a two-row source window, blends the four
// RGB565 neighbours and streams RGB888 pixels on an AXI4-Stream master with backpressure.
module rescale_bilinear_core #(
    parameter int unsigned SRC_WIDTH = 320,
    parameter int unsigned DST_WIDTH = 640,
    parameter int unsigned X_STEP    = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        row_start,
    input  logic [7:0]  fy,
    input  logic [15:0] neighbor0,
    input  logic [15:0] neighbor1,
    input  logic [15:0] neighbor2,
    input  logic [15:0] neighbor3,
    output logic [10:0] neighbor_offset,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        row_done,
    output logic        busy
);
    localparam int unsigned CntW = $clog2(DST_WIDTH + 1);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [18:0]     x_acc_q, x_acc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      fy_q, fy_d;

    logic            pipe_en, issue, last_issue, clamp, beat_accept;
    logic [7:0]      fx;

    logic            s1_valid, s1_last, s2_valid, s2_last;
    logic [15:0]     s1_n0, s1_n1, s1_n2, s1_n3;
    logic [7:0]      s1_fx, s1_fy, s2_fy;
    logic [2:0][5:0] s2_top, s2_bot;
    logic [2:0][7:0] pix;

    // Channel index: 2 = R5, 1 = G6, 0 = B5; 5-bit channels are zero-extended to 6.
    function automatic logic [5:0] chan(input logic [15:0] n, input int idx);
        case (idx)
            2:       return {1'b0, n[15:11]};
            1:       return n[10:5];
            default: return {1'b0, n[4:0]};
        endcase
    endfunction

    function automatic logic [5:0] lerp(input logic [5:0] a, input logic [5:0] b,
                                        input logic [7:0] w);
        logic [14:0] acc;
        acc = 15'(a) * 15'(9'd256 - {1'b0, w}) + 15'(b) * 15'(w) + 15'd128;
        return acc[13:8];
    endfunction

    function automatic logic [7:0] expand(input logic [5:0] v, input logic six);
        return six ? {v, v[5:4]} : {v[4:0], v[4:2]};
    endfunction

    assign pipe_en     = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign beat_accept = M_AXIS_TVALID && M_AXIS_TREADY;
    assign issue       = (state_q == StRun) && pipe_en;
    assign last_issue  = count_q == CntW'(DST_WIDTH - 1);

    // Past the second-to-last column the right neighbour would fall off the row.
    assign clamp           = x_acc_q[18:8] >= 11'(SRC_WIDTH - 1);
    assign neighbor_offset = clamp ? 11'(SRC_WIDTH - 2) : x_acc_q[18:8];
    assign fx              = clamp ? 8'hff : x_acc_q[7:0];

    assign busy = (state_q != StIdle) || row_done;

    always_comb begin
        state_d = state_q;
        x_acc_d = x_acc_q;
        count_d = count_q;
        fy_d    = fy_q;
        case (state_q)
            StIdle: begin
                if (row_start) begin
                    state_d = StRun;
                    x_acc_d = '0;
                    count_d = '0;
                    fy_d    = fy;
                end
            end
            StRun: begin
                if (pipe_en) begin
                    x_acc_d = x_acc_q + 19'(X_STEP);
                    count_d = count_q + CntW'(1);
                    if (last_issue) state_d = StDrain;
                end
            end
            StDrain: begin
                if (beat_accept && M_AXIS_TLAST) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            x_acc_q <= '0;
            count_q <= '0;
            fy_q    <= '0;
        end else begin
            state_q <= state_d;
            x_acc_q <= x_acc_d;
            count_q <= count_d;
            fy_q    <= fy_d;
        end
    end

    always_comb begin
        pix = '0;
        for (int c = 0; c < 3; c++) begin
            pix[c] = expand(lerp(s2_top[c], s2_bot[c], s2_fy), c == 1);
        end
    end

    always_ff @(posedge clock) begin
        if (pipe_en) begin
            s1_n0 <= neighbor0;
            s1_n1 <= neighbor1;
            s1_n2 <= neighbor2;
            s1_n3 <= neighbor3;
            s1_fx <= fx;
            s1_fy <= fy_q;
            s2_fy <= s1_fy;
            for (int c = 0; c < 3; c++) begin
                s2_top[c] <= lerp(chan(s1_n0, c), chan(s1_n1, c), s1_fx);
                s2_bot[c] <= lerp(chan(s1_n2, c), chan(s1_n3, c), s1_fx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_last       <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
            row_done      <= 1'b0;
        end else begin
            row_done <= beat_accept && M_AXIS_TLAST;
            if (pipe_en) begin
                s1_valid      <= issue;
                s1_last       <= issue && last_issue;
                s2_valid      <= s1_valid;
                s2_last       <= s1_valid && s1_last;
                M_AXIS_TVALID <= s2_valid;
                M_AXIS_TLAST  <= s2_valid && s2_last;
                M_AXIS_TDATA  <= {8'h00, pix};
            end
        end
    end
endmodule
